shiftreg_var: RTL and testbench

- Variable-length shift register that stores the snake body trail. Each entry is one segment's direction code. Entry 0 is the newest (head side).
- Successor to the fixed-depth body shift register. Adds an active-length counter, grow/shrink control, a gated shift enable, a random-access read tap, a length-tracking tail output, and full/overflow status.
- Sits between the game-step controller (drives en, grow, shrink, clear) and the renderer and collision logic (use rd_idx/rd_data and tail).

---
 rtl/shiftreg_var_if.sv | 34 +++
 rtl/shiftreg_var.sv | 68 ++++++
 tb/tb_shiftreg_var.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/shiftreg_var_if.sv
// Bundle between the game-step controller (master) and the snake body trail
// register (slave): step controls in, read tap and status out.
interface shiftreg_var_if #(
  parameter int WIDTH = 2,
  parameter int LEN_W = 8
);
  // Timing contract (no valid/ready handshake): en/grow/shrink/clear are
  // sampled on each rising clk edge. All outputs come combinationally from
  // registered state, so rd_data follows rd_idx within the same cycle.
  logic             en;
  logic [WIDTH-1:0] in;
  logic             grow;
  logic             shrink;
  logic             clear;
  logic [LEN_W-1:0] rd_idx;
  logic [WIDTH-1:0] rd_data;
  logic             rd_hit;
  logic [WIDTH-1:0] first;
  logic [WIDTH-1:0] tail;
  logic [LEN_W-1:0] length;
  logic             full;
  logic             empty;
  logic             overflow;

  modport master (
    output en, in, grow, shrink, clear, rd_idx,
    input  rd_data, rd_hit, first, tail, length, full, empty, overflow
  );

  modport slave (
    input  en, in, grow, shrink, clear, rd_idx,
    output rd_data, rd_hit, first, tail, length, full, empty, overflow
  );
endinterface

// File: rtl/shiftreg_var.sv
// Variable-length snake body trail: entry 0 is the head side, and the active
// length decides which entries are visible on the read tap and tail outputs.
module shiftreg_var #(
  parameter  int WIDTH    = 2,
  parameter  int DEPTH    = 220,
  parameter  int INIT_LEN = 3,
  localparam int LEN_W    = $clog2(DEPTH + 1)
) (
  input logic           clk,
  input logic           rst_n,
  shiftreg_var_if.slave bus
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LEN_W-1:0] length_q;
  logic             overflow_q;
  logic             full_w;
  logic             empty_w;
  logic             g;
  logic             s;

  assign full_w  = (length_q == LEN_W'(DEPTH));
  assign empty_w = (length_q == '0);
  assign g       = bus.en & bus.grow & ~full_w;
  assign s       = bus.shrink & ~empty_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.en) begin
      mem[0] <= bus.in;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  // clear wins over grow/shrink; a simultaneous grow and shrink cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      length_q   <= '0;
      overflow_q <= 1'b0;
    end else if (bus.clear) begin
      length_q   <= LEN_W'(INIT_LEN);
      overflow_q <= 1'b0;
    end else begin
      if (g && !s)      length_q <= length_q + LEN_W'(1);
      else if (s && !g) length_q <= length_q - LEN_W'(1);
      if (bus.en && bus.grow && full_w) overflow_q <= 1'b1;
    end
  end

  // Compare-and-select muxes keep every memory access in range for any rd_idx.
  always_comb begin
    bus.rd_data = '0;
    bus.tail    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.rd_hit && (bus.rd_idx == LEN_W'(i))) bus.rd_data = mem[i];
      if (length_q == LEN_W'(i + 1))               bus.tail    = mem[i];
    end
  end

  assign bus.rd_hit   = (bus.rd_idx < length_q);
  assign bus.first    = mem[0];
  assign bus.length   = length_q;
  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_shiftreg_var.sv
// Directed bench for shiftreg_var (DEPTH=8, INIT_LEN=3): the driver queues
// hand-computed expectations, a monitor compares them on each falling edge.
module tb_shiftreg_var;
  localparam int WIDTH    = 2;
  localparam int DEPTH    = 8;
  localparam int INIT_LEN = 3;
  localparam int LEN_W    = $clog2(DEPTH + 1);

  localparam int ID_LEN   = 0;
  localparam int ID_FULL  = 1;
  localparam int ID_EMPTY = 2;
  localparam int ID_OVF   = 3;
  localparam int ID_TAIL  = 4;
  localparam int ID_FIRST = 5;
  localparam int ID_RDAT  = 6;
  localparam int ID_RHIT  = 7;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   done;

  logic [7:0] exp_q[$];
  int         id_q[$];

  shiftreg_var_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  shiftreg_var #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT_LEN(INIT_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d required completion", checks);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step(input logic e, input logic [WIDTH-1:0] d, input logic gr,
                      input logic sh, input logic cl);
    bus.en = e; bus.in = d; bus.grow = gr; bus.shrink = sh; bus.clear = cl;
    @(posedge clk);
    #1;
    bus.en = 1'b0; bus.grow = 1'b0; bus.shrink = 1'b0; bus.clear = 1'b0;
  endtask

  task automatic expect_val(input int id, input logic [7:0] v);
    id_q.push_back(id);
    exp_q.push_back(v);
  endtask

  task automatic expect_status(input int len, input logic fl, input logic em,
                               input logic ov, input int tl);
    expect_val(ID_LEN, 8'(len));
    expect_val(ID_FULL, 8'(fl));
    expect_val(ID_EMPTY, 8'(em));
    expect_val(ID_OVF, 8'(ov));
    expect_val(ID_TAIL, 8'(tl));
  endtask

  // Sets the tap, lets the monitor compare on the next falling edge, returns.
  task automatic rd_chk(input int idx, input int dat, input logic hit);
    bus.rd_idx = LEN_W'(idx);
    expect_val(ID_RDAT, 8'(dat));
    expect_val(ID_RHIT, 8'(hit));
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] actual(input int id);
    case (id)
      ID_LEN:   return 8'(bus.length);
      ID_FULL:  return 8'(bus.full);
      ID_EMPTY: return 8'(bus.empty);
      ID_OVF:   return 8'(bus.overflow);
      ID_TAIL:  return 8'(bus.tail);
      ID_FIRST: return 8'(bus.first);
      ID_RDAT:  return 8'(bus.rd_data);
      default:  return 8'(bus.rd_hit);
    endcase
  endfunction

  function automatic string id_name(input int id);
    case (id)
      ID_LEN:   return "length";
      ID_FULL:  return "full";
      ID_EMPTY: return "empty";
      ID_OVF:   return "overflow";
      ID_TAIL:  return "tail";
      ID_FIRST: return "first";
      ID_RDAT:  return "rd_data";
      default:  return "rd_hit";
    endcase
  endfunction

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      while (id_q.size() > 0) begin
        automatic int         id = id_q.pop_front();
        automatic logic [7:0] ev = exp_q.pop_front();
        automatic logic [7:0] av = actual(id);
        checks++;
        if (av !== ev) begin
          errors++;
          $display("FAIL %s at %0t (rd_idx=%0d): got %0d expected %0d",
                   id_name(id), $time, bus.rd_idx, av, ev);
        end
      end
    end
  end

  // directed stimulus
  initial begin
    checks = 0; errors = 0; done = 1'b0;
    bus.en = 1'b0; bus.in = '0; bus.grow = 1'b0; bus.shrink = 1'b0;
    bus.clear = 1'b0; bus.rd_idx = '0;
    rst_n = 1'b0;
    #2;
    expect_status(0, 0, 1, 0, 0);
    expect_val(ID_FIRST, 8'd0);
    rd_chk(0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: clear after reset
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    expect_status(3, 0, 0, 0, 0);
    rd_chk(0, 0, 1); rd_chk(1, 0, 1); rd_chk(2, 0, 1); rd_chk(3, 0, 0);

    // 2: shift without grow -> mem = 0,3,2,1,...
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    expect_status(3, 0, 0, 0, 2);
    expect_val(ID_FIRST, 8'd0);
    rd_chk(0, 0, 1); rd_chk(1, 3, 1); rd_chk(2, 2, 1);

    // 3: grow to full -> mem = 2,1,3,2,1,0,3,2
    step(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    expect_status(8, 1, 0, 0, 2);
    step(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);  // mem = 3,2,1,3,2,1,0,3
    expect_status(8, 1, 0, 1, 3);
    rd_chk(7, 3, 1); rd_chk(8, 0, 0); rd_chk(15, 0, 0);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    expect_status(3, 0, 0, 0, 1);

    // 4: grow to 5, then grow+shrink together, then shrink to empty
    step(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);  // mem = 1,0,3,2,1,3,2,1
    expect_status(5, 0, 0, 0, 1);
    step(1'b1, 2'd2, 1'b1, 1'b1, 1'b0);  // mem = 2,1,0,3,2,1,3,2
    expect_status(5, 0, 0, 0, 2);
    expect_val(ID_FIRST, 8'd2);
    begin
      int exp_len[6]  = '{4, 3, 2, 1, 0, 0};
      int exp_tail[6] = '{3, 0, 1, 2, 0, 0};
      for (int i = 0; i < 6; i++) begin
        step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        expect_val(ID_LEN, 8'(exp_len[i]));
        expect_val(ID_TAIL, 8'(exp_tail[i]));
      end
    end
    expect_val(ID_EMPTY, 8'd1);
    rd_chk(0, 0, 0);

    // 5: grow without en leaves everything alone, including a set overflow
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 2'd3, 1'b1, 1'b0, 1'b0);
    expect_status(3, 0, 0, 0, 0);
    expect_val(ID_FIRST, 8'd2);
    rd_chk(1, 1, 1);
    repeat (6) step(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);  // mem = 0,0,0,0,0,0,2,1
    expect_status(8, 1, 0, 1, 1);
    repeat (3) step(1'b0, 2'd3, 1'b1, 1'b0, 1'b0);
    expect_status(8, 1, 0, 1, 1);
    expect_val(ID_FIRST, 8'd0);

    // 6: async reset while running at length 6
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);  // mem = 3,2,1,0,...
    expect_status(6, 0, 0, 0, 0);
    expect_val(ID_FIRST, 8'd3);
    bus.en = 1'b1; bus.in = 2'd2; bus.grow = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    expect_status(0, 0, 1, 0, 0);
    expect_val(ID_FIRST, 8'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1; bus.en = 1'b0; bus.grow = 1'b0;
    step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    expect_status(0, 0, 1, 0, 0);
    expect_val(ID_FIRST, 8'd3);
    rd_chk(0, 0, 0);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    expect_status(3, 0, 0, 0, 0);
    rd_chk(0, 3, 1);

    @(negedge clk);
    #1;
    if (id_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", id_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    done = 1'b1;
    $finish;
  end

endmodule
